// File: rtl/c0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// c0_exc_ctrl
//
// Coprocessor-0 exception/interrupt sequencer. Owns Status, Cause and EPC,
// decides when to take a synchronous exception or a hardware interrupt, and
// drives the flush/redirect handshake into EXC_VECTOR (and back to EPC on
// ERET). Also services mtc0/mfc0/di/ei.
//
// Ports
//   sys_clk, rst_n      clock, synchronous active-low reset
//   irq_i               level-sensitive interrupt lines (NUM_IRQ wide)
//   exc_req_i           synchronous exception pulse, with exc_code_i/exc_pc_i
//   eret_i/di_i/ei_i    decoded ERET / DI / EI pulses
//   mtc0_we_i           CP0 write strobe, mtc0_addr_i/mtc0_data_i
//   mfc0_addr_i         CP0 read address -> mfc0_data_o (combinational)
//   pipe_ready_i        pipeline drained, may accept a redirect
//   flush_o             kill in-flight instructions (FLUSH state)
//   redirect_o          one-cycle redirect strobe, target redirect_pc_o
//   busy_o              controller not idle, pipeline must stall issue
//   status_o/cause_o/epc_o  live register values
// ---------------------------------------------------------------------------
module c0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          NUM_IRQ    = 6
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               exc_req_i,
    input  logic [4:0]         exc_code_i,
    input  logic [31:0]        exc_pc_i,
    input  logic               eret_i,
    input  logic               di_i,
    input  logic               ei_i,
    input  logic               mtc0_we_i,
    input  logic [4:0]         mtc0_addr_i,
    input  logic [31:0]        mtc0_data_i,
    input  logic [4:0]         mfc0_addr_i,
    input  logic               pipe_ready_i,
    output logic [31:0]        mfc0_data_o,
    output logic               flush_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic               busy_o,
    output logic [31:0]        status_o,
    output logic [31:0]        cause_o,
    output logic [31:0]        epc_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    logic [1:0]         state_q;
    logic               ie_q;
    logic               exl_q;
    logic [NUM_IRQ-1:0] im_q;
    logic [4:0]         exc_code_q;
    logic [31:0]        epc_q;
    logic [31:0]        redirect_pc_q;
    logic               int_take;

    // Uses registered IE/IM/EXL only, so an enable written this cycle can
    // first cause an entry on the following cycle.
    assign int_take = ie_q & ~exl_q & (|(irq_i & im_q));

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ie_q          <= 1'b0;
            exl_q         <= 1'b0;
            im_q          <= '0;
            exc_code_q    <= 5'd0;
            epc_q         <= 32'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Entry and ERET take precedence; a coincident
                    // mtc0/di/ei is deliberately dropped.
                    if (exc_req_i) begin
                        epc_q         <= exc_pc_i;
                        exc_code_q    <= exc_code_i;
                        exl_q         <= 1'b1;
                        redirect_pc_q <= EXC_VECTOR;
                        state_q       <= ST_FLUSH;
                    end else if (int_take) begin
                        epc_q         <= exc_pc_i;
                        exc_code_q    <= 5'd0;
                        exl_q         <= 1'b1;
                        redirect_pc_q <= EXC_VECTOR;
                        state_q       <= ST_FLUSH;
                    end else if (eret_i) begin
                        exl_q         <= 1'b0;
                        redirect_pc_q <= epc_q;
                        state_q       <= ST_REDIRECT;
                    end else begin
                        if (di_i) ie_q <= 1'b0;
                        if (ei_i) ie_q <= 1'b1;
                        // mtc0 is applied last so it wins over di/ei.
                        if (mtc0_we_i) begin
                            case (mtc0_addr_i)
                                ADDR_STATUS: begin
                                    ie_q  <= mtc0_data_i[0];
                                    exl_q <= mtc0_data_i[1];
                                    im_q  <= mtc0_data_i[8 +: NUM_IRQ];
                                end
                                ADDR_CAUSE: exc_code_q <= mtc0_data_i[6:2];
                                ADDR_EPC:   epc_q      <= mtc0_data_i;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_FLUSH: begin
                    if (pipe_ready_i) state_q <= ST_REDIRECT;
                end
                ST_REDIRECT: state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode purely from registered state.
    assign flush_o       = (state_q == ST_FLUSH);
    assign redirect_o    = (state_q == ST_REDIRECT);
    assign busy_o        = (state_q != ST_IDLE);
    assign redirect_pc_o = redirect_pc_q;
    assign epc_o         = epc_q;

    always_comb begin
        status_o                  = 32'd0;
        status_o[0]               = ie_q;
        status_o[1]               = exl_q;
        status_o[8 +: NUM_IRQ]    = im_q;
        // IP is a live view of the request lines, not a stored field.
        cause_o                   = 32'd0;
        cause_o[6:2]              = exc_code_q;
        cause_o[8 +: NUM_IRQ]     = irq_i;
    end

    always_comb begin
        mfc0_data_o = 32'd0;
        case (mfc0_addr_i)
            ADDR_STATUS: mfc0_data_o = status_o;
            ADDR_CAUSE:  mfc0_data_o = cause_o;
            ADDR_EPC:    mfc0_data_o = epc_q;
            default:     mfc0_data_o = 32'd0;
        endcase
    end

endmodule

// File: doc/c0_exc_ctrl.md
# c0_exc_ctrl

Exception/interrupt sequencer for coprocessor 0. It owns the Status, Cause and EPC registers and decides when to take an interrupt or synchronous exception. It drives the pipeline flush-and-redirect handshake into the exception vector, and back out on ERET. It sits beside the fetch/decode stages and serves mtc0/mfc0/di/ei/eret decoded from coprocessor-0 instructions.

## Interface
- EXC_VECTOR, 32'h0000_0180, redirect target on exception/interrupt entry
- NUM_IRQ, 6, number of hardware interrupt lines (1..8)
- sys_clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low; clock sys_clk
- irq_i  in  NUM_IRQ  level-sensitive interrupt requests
- exc_req_i  in  1  synchronous exception from pipeline (one-cycle pulse, valid only when busy_o=0)
- exc_code_i  in  5  ExcCode accompanying exc_req_i
- exc_pc_i  in  32  EPC to save (faulting PC, or next PC to resume for interrupts)
- eret_i, di_i, ei_i  in  1 each  decoded ERET / DI / EI, one-cycle pulses
- mtc0_we_i  in  1  write strobe; mtc0_addr_i in 5; mtc0_data_i in 32
- mfc0_addr_i  in  5  read address
- pipe_ready_i  in  1  pipeline drained and can accept a redirect
- mfc0_data_o  out  32  combinational read of register mfc0_addr_i (12 Status, 13 Cause, 14 EPC, else 0)
- flush_o  out  1  kill in-flight instructions
- redirect_o  out  1  one-cycle PC redirect strobe; redirect_pc_o out 32 target
- busy_o  out  1  controller not IDLE; pipeline must stall issue
- status_o, cause_o, epc_o  out  32 each  live register values

## Operation
- Status: bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM; other bits read 0, writes ignored. Cause: bits[6:2] ExcCode, bits[8+NUM_IRQ-1:8] IP; IP mirrors irq_i each cycle and is not writable. EPC is fully writable.
- int_take = IE & ~EXL & |(irq_i & IM).
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE, priority order:
  - exc_req_i: EPC<=exc_pc_i, ExcCode<=exc_code_i, EXL<=1, redirect_pc<=EXC_VECTOR, ->FLUSH.
  - else int_take: same, with ExcCode<=0.
  - else eret_i: EXL<=0, redirect_pc<=EPC, ->REDIRECT (no flush).
  - else apply di_i (IE<=0), ei_i (IE<=1), then mtc0 write.
- An mtc0/di/ei coinciding with an entry or ERET is dropped; entry/ERET field updates win.
- FLUSH: flush_o=1; stay until pipe_ready_i=1, then ->REDIRECT.
- REDIRECT: redirect_o=1 for exactly one cycle, ->IDLE.
- Outside IDLE: exc_req_i, eret_i, di_i, ei_i and mtc0 are ignored. IP keeps tracking irq_i.
- An interrupt asserted while EXL=1 is held pending in IP. It is taken in the first IDLE cycle after EXL clears and IE=1.

## Timing
- Reset: state IDLE; Status, Cause (except IP), EPC, redirect_pc_o = 0; flush_o, redirect_o, busy_o = 0. Reset in any state aborts the sequence immediately.
- flush_o, redirect_o and busy_o decode from registered state, with no combinational path from inputs.
- Entry detected at edge T: at T+1 registers are updated, flush_o=1, busy_o=1.
  - If pipe_ready_i=1 during T+1: redirect_o=1 at T+2, IDLE at T+3.
  - If pipe_ready_i is held low, FLUSH persists indefinitely.
- ERET at T: EXL=0 and redirect_o=1 at T+1 with redirect_pc_o=EPC; IDLE at T+2.
- mtc0/di/ei take effect at T+1. mfc0_data_o reflects the new value from T+1. int_take uses registered IE/IM, so an interrupt enabled at T can be taken at T+1 at the earliest.

## Test plan
- Reset, then read 12/13/14 → all 0. mtc0 Status=32'h0000_0401 → status_o=32'h401. Reads of addr 5 → 0.
- IM bit2 and IE set, irq_i=6'b000100, exc_pc_i=32'h0040_0020, pipe_ready_i low 3 cycles:
  - flush_o high 4 cycles, then one redirect_o with redirect_pc_o=32'h180.
  - EPC=32'h0040_0020, ExcCode=0, EXL=1, Cause IP=3'b100 in bits[10:8].
- exc_req_i with exc_code_i=8 (syscall) in the same cycle as a live enabled interrupt → ExcCode=8; the syscall wins.
- ERET with EPC=32'h0040_0024 → redirect_o one cycle later with target 32'h0040_0024, EXL=0, flush_o never asserted.
- irq_i held through handler (EXL=1) → no re-entry; after ERET returns to IDLE, re-entry within 1 cycle. DI beforehand → no entry.
- rst_n low during FLUSH → next cycle flush_o=0, busy_o=0, EPC=0; mtc0 issued while busy_o=1 leaves registers unchanged.
